// File: rtl/motor_pwm_driver.sv
// Two-channel H-bridge PWM driver: latches direction/duty at PWM period boundaries and inserts dead-time coast on reversal.
// Optional build macro SOFT_START_EN ramps duty up by RAMP_STEP per period on entry to drive.
module motor_pwm_driver #(
  parameter int PRESCALE         = 4,
  parameter int DEADTIME_PERIODS = 2,
  parameter int RAMP_STEP        = 4
) (
  input  logic       clk_3125KHz,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       m1_a,
  input  logic       m1_b,
  input  logic       m2_a,
  input  logic       m2_b,
  input  logic [4:0] dc1,
  input  logic [4:0] dc2,
  output logic       m1_in1,
  output logic       m1_in2,
  output logic       m2_in1,
  output logic       m2_in2,
  output logic       period_start,
  output logic [1:0] dir_fault
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEADTIME_PERIODS > 0) ? $clog2(DEADTIME_PERIODS + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DEAD_INIT = DW'(DEADTIME_PERIODS);
  localparam logic [5:0]    RAMP_SAT  = (RAMP_STEP > 31) ? 6'd31 : 6'(RAMP_STEP);

  typedef enum logic [1:0] {
    ST_COAST,
    ST_DRIVE,
    ST_DEAD
  } chan_state_t;

  logic [PW-1:0] presc_q;
  logic [4:0]    pwm_cnt_q;
  logic          tick;
  logic          boundary;

  chan_state_t   state_q [2];
  chan_state_t   state_d [2];
  logic [1:0]    rev_q, rev_d;
  logic [4:0]    duty_q  [2];
  logic [4:0]    duty_d  [2];
  logic [DW-1:0] dead_q  [2];
  logic [DW-1:0] dead_d  [2];
  logic [1:0]    in1_d, in2_d, fault_d;
  logic [1:0]    in1_q, in2_q;

  logic [1:0]    req_a, req_b;
  logic [4:0]    dc_sel  [2];

  assign req_a     = {m2_a, m1_a};
  assign req_b     = {m2_b, m1_b};
  assign dc_sel[0] = dc1;
  assign dc_sel[1] = dc2;

  assign tick     = (presc_q == PRESC_MAX);
  assign boundary = tick && (pwm_cnt_q == 5'd31);

  // Soft-start duty helpers: first step capped at RAMP_STEP, then grow by RAMP_STEP saturating at 31.
  function automatic logic [4:0] ramp_entry(input logic [4:0] dc);
    return ({1'b0, dc} < RAMP_SAT) ? dc : RAMP_SAT[4:0];
  endfunction

  function automatic logic [4:0] ramp_next(input logic [4:0] dc, input logic [4:0] cur);
    logic [5:0] sum;
    sum = {1'b0, cur} + RAMP_SAT;
    if (sum > 6'd31) sum = 6'd31;
    return ({1'b0, dc} < sum) ? dc : sum[4:0];
  endfunction

  function automatic logic [4:0] entry_duty(input logic [4:0] dc);
`ifdef SOFT_START_EN
    return ramp_entry(dc);
`else
    return dc;
`endif
  endfunction

  function automatic logic [4:0] run_duty(input logic [4:0] dc, input logic [4:0] cur);
`ifdef SOFT_START_EN
    return ramp_next(dc, cur);
`else
    if (cur == 5'd31) return dc;
    return dc;
`endif
  endfunction

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) pwm_cnt_q <= pwm_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_COAST;
        duty_q[i]  <= '0;
        dead_q[i]  <= '0;
      end
      rev_q        <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      dir_fault    <= '0;
      period_start <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        duty_q[i]  <= duty_d[i];
        dead_q[i]  <= dead_d[i];
      end
      rev_q        <= rev_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      dir_fault    <= fault_d;
      period_start <= boundary;
    end
  end

  // Per-channel next state; enable low overrides any boundary update.
  always_comb begin
    rev_d   = rev_q;
    in1_d   = '0;
    in2_d   = '0;
    fault_d = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      duty_d[i]  = duty_q[i];
      dead_d[i]  = dead_q[i];

      in1_d[i] = enable && (state_q[i] == ST_DRIVE) && !rev_q[i] && (pwm_cnt_q < duty_q[i]);
      in2_d[i] = enable && (state_q[i] == ST_DRIVE) &&  rev_q[i] && (pwm_cnt_q < duty_q[i]);

      if (!enable) begin
        state_d[i] = ST_COAST;
        duty_d[i]  = '0;
        dead_d[i]  = '0;
      end else if (boundary) begin
        fault_d[i] = req_a[i] && req_b[i];
        case (state_q[i])
          ST_COAST: begin
            if (req_a[i] ^ req_b[i]) begin
              state_d[i] = ST_DRIVE;
              rev_d[i]   = req_b[i];
              duty_d[i]  = entry_duty(dc_sel[i]);
            end
          end
          ST_DRIVE: begin
            if (!(req_a[i] ^ req_b[i])) begin
              state_d[i] = ST_COAST;
              duty_d[i]  = '0;
            end else if (req_b[i] == rev_q[i]) begin
              duty_d[i] = run_duty(dc_sel[i], duty_q[i]);
            end else if (DEADTIME_PERIODS == 0) begin
              rev_d[i]  = req_b[i];
              duty_d[i] = entry_duty(dc_sel[i]);
            end else begin
              state_d[i] = ST_DEAD;
              dead_d[i]  = DEAD_INIT;
              duty_d[i]  = '0;
            end
          end
          ST_DEAD: begin
            if (!(req_a[i] ^ req_b[i])) begin
              state_d[i] = ST_COAST;
              dead_d[i]  = '0;
            end else if (dead_q[i] <= DW'(1)) begin
              state_d[i] = ST_DRIVE;
              rev_d[i]   = req_b[i];
              duty_d[i]  = entry_duty(dc_sel[i]);
              dead_d[i]  = '0;
            end else begin
              dead_d[i] = dead_q[i] - DW'(1);
            end
          end
          default: begin
            state_d[i] = ST_COAST;
            duty_d[i]  = '0;
            dead_d[i]  = '0;
          end
        endcase
      end
    end
  end

  assign m1_in1 = in1_q[0];
  assign m1_in2 = in2_q[0];
  assign m2_in1 = in1_q[1];
  assign m2_in2 = in2_q[1];

endmodule
